// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: instruction ids, datapath
// select values and the sequencer state type.
package ctrl_pkg;

    localparam logic [7:0] ID_BR_LO = 8'h04;
    localparam logic [7:0] ID_BR_HI = 8'h08;
    localparam logic [7:0] ID_CLI   = 8'h0A;
    localparam logic [7:0] ID_IN    = 8'h11;
    localparam logic [7:0] ID_LD    = 8'h19;
    localparam logic [7:0] ID_OUT   = 8'h29;
    localparam logic [7:0] ID_POP   = 8'h2A;
    localparam logic [7:0] ID_PUSH  = 8'h2B;
    localparam logic [7:0] ID_RCALL = 8'h2C;
    localparam logic [7:0] ID_RET   = 8'h2D;
    localparam logic [7:0] ID_RETI  = 8'h2E;
    localparam logic [7:0] ID_RJMP  = 8'h2F;
    localparam logic [7:0] ID_SEI   = 8'h32;
    localparam logic [7:0] ID_ST    = 8'h38;

    localparam logic [2:0] ADDR_Y     = 3'd0;
    localparam logic [2:0] ADDR_ARG2  = 3'd1;
    localparam logic [2:0] ADDR_SP    = 3'd2;
    localparam logic [2:0] ADDR_SP_PI = 3'd3;
    localparam logic [2:0] ADDR_SREG  = 3'd4;

    localparam logic [2:0] DATA_RD1  = 3'd0;
    localparam logic [2:0] DATA_PC_L = 3'd1;
    localparam logic [2:0] DATA_PC_H = 3'd2;
    localparam logic [2:0] DATA_SREG = 3'd3;
    localparam logic [2:0] DATA_PC_X = 3'd4;

    localparam logic [1:0] PC_SEL_VEC = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_REL = 2'd2;
    localparam logic [1:0] PC_SEL_POP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_IRQ  = 2'd2
    } state_e;

    // Return-address pushes go out low byte first.
    function automatic logic [2:0] push_data_sel(input int step);
        case (step)
            0:       return DATA_PC_L;
            1:       return DATA_PC_H;
            default: return DATA_PC_X;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// Combinational decode of sequencer state/step/instruction into datapath
// selects and strobes. Outputs depend only on registered sequencer state.
module ctrl_step_decode
    import ctrl_pkg::*;
#(
    parameter int PC_BYTES = 2,
    parameter int ID_W     = 8,
    parameter int STEP_W   = 2
) (
    input  logic [1:0]          state,
    input  logic [ID_W-1:0]     instr,
    input  logic [STEP_W-1:0]   step,
    input  logic                last,
    output logic [2:0]          mm_addr_sel,
    output logic [2:0]          mm_data_sel,
    output logic                mm_we,
    output logic                sp_dec,
    output logic                sp_inc,
    output logic [PC_BYTES-1:0] pc_byte_we,
    output logic                pc_load,
    output logic [1:0]          pm_pc_new_sel,
    output logic                irq_ack,
    output logic                i_set,
    output logic                i_clr
);

    logic is_irq;
    logic is_exec;
    logic is_rcall;
    logic is_ret;

    always_comb begin
        mm_addr_sel   = ADDR_Y;
        mm_data_sel   = DATA_RD1;
        mm_we         = 1'b0;
        sp_dec        = 1'b0;
        sp_inc        = 1'b0;
        pc_byte_we    = '0;
        pc_load       = 1'b0;
        pm_pc_new_sel = PC_SEL_VEC;
        irq_ack       = 1'b0;
        i_set         = 1'b0;
        i_clr         = 1'b0;

        is_irq   = (state == ST_IRQ);
        is_exec  = (state == ST_EXEC);
        is_rcall = is_exec && (instr == ID_W'(ID_RCALL));
        is_ret   = is_exec && ((instr == ID_W'(ID_RET)) || (instr == ID_W'(ID_RETI)));

        if (is_irq || is_rcall) begin
            if (last) begin
                pc_load = 1'b1;
                if (is_irq) begin
                    pm_pc_new_sel = PC_SEL_VEC;
                    irq_ack       = 1'b1;
                    i_clr         = 1'b1;
                end else begin
                    pm_pc_new_sel = PC_SEL_REL;
                end
            end else begin
                mm_addr_sel = ADDR_SP;
                mm_data_sel = push_data_sel(int'(step));
                mm_we       = 1'b1;
                sp_dec      = 1'b1;
            end
        end else if (is_ret) begin
            if (last) begin
                pc_load       = 1'b1;
                pm_pc_new_sel = PC_SEL_POP;
                i_set         = (instr == ID_W'(ID_RETI));
            end else begin
                // Pops arrive high byte first, so the staging lane counts down.
                mm_addr_sel = ADDR_SP_PI;
                sp_inc      = 1'b1;
                for (int i = 0; i < PC_BYTES; i++) begin
                    pc_byte_we[i] = (i == PC_BYTES - 1 - int'(step));
                end
            end
        end else if (is_exec) begin
            case (instr)
                ID_W'(ID_PUSH): begin
                    mm_addr_sel = ADDR_SP;
                    mm_data_sel = DATA_RD1;
                    mm_we       = 1'b1;
                    sp_dec      = 1'b1;
                end
                ID_W'(ID_POP): begin
                    mm_addr_sel = ADDR_SP_PI;
                    sp_inc      = 1'b1;
                end
                ID_W'(ID_LD): mm_addr_sel = ADDR_Y;
                ID_W'(ID_ST): begin
                    mm_addr_sel = ADDR_Y;
                    mm_we       = 1'b1;
                end
                ID_W'(ID_IN): mm_addr_sel = ADDR_ARG2;
                ID_W'(ID_OUT): begin
                    mm_addr_sel = ADDR_ARG2;
                    mm_we       = 1'b1;
                end
                ID_W'(ID_CLI), ID_W'(ID_SEI): begin
                    mm_addr_sel = ADDR_SREG;
                    mm_data_sel = DATA_SREG;
                    mm_we       = 1'b1;
                end
                ID_W'(ID_RJMP): begin
                    pc_load       = 1'b1;
                    pm_pc_new_sel = PC_SEL_REL;
                end
                default: begin
                    if (instr >= ID_W'(ID_BR_LO) && instr <= ID_W'(ID_BR_HI)) begin
                        pc_load       = 1'b1;
                        pm_pc_new_sel = PC_SEL_BR;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle AVR control sequencer: accepts decoded instructions, runs the
// call/return/interrupt-entry stack sequences and stalls fetch meanwhile.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int PC_BYTES = 2,
    parameter int ID_W     = 8,
    parameter int STEP_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [ID_W-1:0]     instruction_id,
    output logic                instr_ready,
    input  logic                irq_req,
    input  logic                i_flag,
    output logic                irq_ack,
    output logic                busy,
    output logic [2:0]          mm_addr_sel,
    output logic [2:0]          mm_data_sel,
    output logic                mm_we,
    output logic                sp_dec,
    output logic                sp_inc,
    output logic [PC_BYTES-1:0] pc_byte_we,
    output logic                pc_load,
    output logic [1:0]          pm_pc_new_sel,
    output logic                i_set,
    output logic                i_clr
);

    localparam logic [STEP_W:0] LEN_ONE = (STEP_W+1)'(1);
    localparam logic [STEP_W:0] LEN_SEQ = (STEP_W+1)'(PC_BYTES + 1);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [ID_W-1:0]     instr_q, instr_d;
    logic [STEP_W:0]     len_q, len_d;

    logic active;
    logic last;
    logic bad_step;
    logic open_slot;
    logic take_irq;
    logic accept;
    logic multi;

    always_comb begin
        active    = (state_q != ST_IDLE);
        last      = active && ({1'b0, step_q} == len_q - LEN_ONE);
        bad_step  = active && ({1'b0, step_q} >= len_q);
        open_slot = !active || last;
        take_irq  = irq_req & i_flag & open_slot;
        instr_ready = open_slot & !take_irq;
        accept    = instr_valid & instr_ready;
        busy      = active & !last;
        multi     = (instruction_id == ID_W'(ID_RCALL)) ||
                    (instruction_id == ID_W'(ID_RET))   ||
                    (instruction_id == ID_W'(ID_RETI));

        state_d = state_q;
        step_d  = active ? step_q + 1'b1 : '0;
        instr_d = instr_q;
        len_d   = len_q;

        // An out-of-range step can only come from corruption; park safely.
        if (bad_step) begin
            state_d = ST_IDLE;
            step_d  = '0;
        end else if (take_irq) begin
            state_d = ST_IRQ;
            step_d  = '0;
            len_d   = LEN_SEQ;
        end else if (accept) begin
            state_d = ST_EXEC;
            step_d  = '0;
            instr_d = instruction_id;
            len_d   = multi ? LEN_SEQ : LEN_ONE;
        end else if (last) begin
            state_d = ST_IDLE;
            step_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            instr_q <= '0;
            len_q   <= LEN_ONE;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            instr_q <= instr_d;
            len_q   <= len_d;
        end
    end

    ctrl_step_decode #(
        .PC_BYTES (PC_BYTES),
        .ID_W     (ID_W),
        .STEP_W   (STEP_W)
    ) u_decode (
        .state         (state_q),
        .instr         (instr_q),
        .step          (step_q),
        .last          (last),
        .mm_addr_sel   (mm_addr_sel),
        .mm_data_sel   (mm_data_sel),
        .mm_we         (mm_we),
        .sp_dec        (sp_dec),
        .sp_inc        (sp_inc),
        .pc_byte_we    (pc_byte_we),
        .pc_load       (pc_load),
        .pm_pc_new_sel (pm_pc_new_sel),
        .irq_ack       (irq_ack),
        .i_set         (i_set),
        .i_clr         (i_clr)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (2- and 3-byte PC) share stimulus
// and are each compared against a script-queue model of the expected outputs.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instruction_id;
    logic       irq_req;
    logic       i_flag;

    logic       instr_ready_a, irq_ack_a, busy_a, mm_we_a, sp_dec_a, sp_inc_a;
    logic       pc_load_a, i_set_a, i_clr_a;
    logic [2:0] mm_addr_sel_a, mm_data_sel_a;
    logic [1:0] pc_byte_we_a, pm_pc_new_sel_a;

    logic       instr_ready_b, irq_ack_b, busy_b, mm_we_b, sp_dec_b, sp_inc_b;
    logic       pc_load_b, i_set_b, i_clr_b;
    logic [2:0] mm_addr_sel_b, mm_data_sel_b, pc_byte_we_b;
    logic [1:0] pm_pc_new_sel_b;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt, busy_cnt, rdy_cnt, ack_cnt;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [7:0]  ids [16];

    always #5 clk = ~clk;

    control_sequencer #(.PC_BYTES(2), .ID_W(8), .STEP_W(2)) dut_a (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .instruction_id(instruction_id), .instr_ready(instr_ready_a),
        .irq_req(irq_req), .i_flag(i_flag), .irq_ack(irq_ack_a), .busy(busy_a),
        .mm_addr_sel(mm_addr_sel_a), .mm_data_sel(mm_data_sel_a), .mm_we(mm_we_a),
        .sp_dec(sp_dec_a), .sp_inc(sp_inc_a), .pc_byte_we(pc_byte_we_a),
        .pc_load(pc_load_a), .pm_pc_new_sel(pm_pc_new_sel_a),
        .i_set(i_set_a), .i_clr(i_clr_a)
    );

    control_sequencer #(.PC_BYTES(3), .ID_W(8), .STEP_W(2)) dut_b (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .instruction_id(instruction_id), .instr_ready(instr_ready_b),
        .irq_req(irq_req), .i_flag(i_flag), .irq_ack(irq_ack_b), .busy(busy_b),
        .mm_addr_sel(mm_addr_sel_b), .mm_data_sel(mm_data_sel_b), .mm_we(mm_we_b),
        .sp_dec(sp_dec_b), .sp_inc(sp_inc_b), .pc_byte_we(pc_byte_we_b),
        .pc_load(pc_load_b), .pm_pc_new_sel(pm_pc_new_sel_b),
        .i_set(i_set_b), .i_clr(i_clr_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic [2:0] a, input logic [2:0] d,
                                       input logic we, input logic dec, input logic inc,
                                       input logic [2:0] pbw, input logic ld,
                                       input logic [1:0] sel, input logic ack,
                                       input logic iset, input logic iclr);
        return {14'd0, a, d, we, dec, inc, pbw, ld, sel, ack, iset, iclr};
    endfunction

    function automatic int seq_len(input int pcb, input logic is_irq, input logic [7:0] id);
        if (is_irq || id == 8'h2C || id == 8'h2D || id == 8'h2E) return pcb + 1;
        return 1;
    endfunction

    // Expected output word for cycle s of the sequence started by an IRQ or by id.
    function automatic logic [31:0] seq_entry(input int pcb, input logic is_irq,
                                              input logic [7:0] id, input int s);
        logic [2:0]  dsel;
        logic [31:0] push_w;
        dsel   = (s == 0) ? 3'd1 : ((s == 1) ? 3'd2 : 3'd4);
        push_w = pk(3'd2, dsel, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        if (is_irq)
            return (s < pcb) ? push_w
                             : pk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
        case (id)
            8'h2C: return (s < pcb) ? push_w
                                    : pk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
            8'h2D, 8'h2E:
                return (s < pcb) ? pk(3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 3'(1 << (pcb - 1 - s)),
                                      1'b0, 2'd0, 1'b0, 1'b0, 1'b0)
                                 : pk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 2'd3,
                                      1'b0, (id == 8'h2E), 1'b0);
            8'h2B: return pk(3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            8'h2A: return pk(3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            8'h38: return pk(3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            8'h11: return pk(3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            8'h29: return pk(3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            8'h0A, 8'h32:
                   return pk(3'd4, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            8'h2F: return pk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
            default:
                if (id >= 8'h04 && id <= 8'h08)
                    return pk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
                else
                    return 32'd0;
        endcase
    endfunction

    // Compare one instance against its model queue; returns what the model takes next.
    task automatic check_side(input string nm, input int sz, input logic [31:0] cur,
                              input logic [31:0] got, input logic rdy, input logic bsy,
                              output logic tk, output logic acc);
        logic open_s;
        open_s = (sz <= 1);
        tk     = irq_req & i_flag & open_s;
        acc    = instr_valid & open_s & !tk;
        chk({nm, ".outs"}, got, cur);
        chk({nm, ".instr_ready"}, {31'd0, rdy}, {31'd0, open_s & !tk});
        chk({nm, ".busy"}, {31'd0, bsy}, {31'd0, sz > 1});
    endtask

    task automatic cyc(input logic v, input logic [7:0] id, input logic irq,
                       input logic fl, input logic rs);
        logic [31:0] got_a, got_b, cur_a, cur_b;
        logic        tk_a, acc_a, tk_b, acc_b;
        instr_valid    = v;
        instruction_id = id;
        irq_req        = irq;
        i_flag         = fl;
        reset          = rs;
        @(negedge clk);
        got_a = pk(mm_addr_sel_a, mm_data_sel_a, mm_we_a, sp_dec_a, sp_inc_a,
                   {1'b0, pc_byte_we_a}, pc_load_a, pm_pc_new_sel_a, irq_ack_a, i_set_a, i_clr_a);
        got_b = pk(mm_addr_sel_b, mm_data_sel_b, mm_we_b, sp_dec_b, sp_inc_b,
                   pc_byte_we_b, pc_load_b, pm_pc_new_sel_b, irq_ack_b, i_set_b, i_clr_b);
        cur_a = (q_a.size() > 0) ? q_a[0] : 32'd0;
        cur_b = (q_b.size() > 0) ? q_b[0] : 32'd0;
        check_side("pc2", q_a.size(), cur_a, got_a, instr_ready_a, busy_a, tk_a, acc_a);
        check_side("pc3", q_b.size(), cur_b, got_b, instr_ready_b, busy_b, tk_b, acc_b);
        we_cnt   += int'(mm_we_a);
        busy_cnt += int'(busy_a);
        rdy_cnt  += int'(instr_ready_a);
        ack_cnt  += int'(irq_ack_a);

        if (rs) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (q_a.size() > 0) void'(q_a.pop_front());
            if (q_b.size() > 0) void'(q_b.pop_front());
            if (tk_a || acc_a)
                for (int s = 0; s < seq_len(2, tk_a, id); s++) q_a.push_back(seq_entry(2, tk_a, id, s));
            if (tk_b || acc_b)
                for (int s = 0; s < seq_len(3, tk_b, id); s++) q_b.push_back(seq_entry(3, tk_b, id, s));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic zero_counts();
        we_cnt = 0; busy_cnt = 0; rdy_cnt = 0; ack_cnt = 0;
    endtask

    initial begin
        ids = '{8'h2C, 8'h2D, 8'h2E, 8'h2B, 8'h2A, 8'h19, 8'h38, 8'h11,
                8'h29, 8'h0A, 8'h32, 8'h04, 8'h08, 8'h2F, 8'h06, 8'h00};
        zero_counts();
        reset = 1'b1; instr_valid = 1'b0; instruction_id = 8'h00;
        irq_req = 1'b0; i_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // RCALL, then RETI (longer on the 3-byte instance)
        cyc(1'b1, 8'h2C, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h2E, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // IRQ races a PUSH; PUSH stays presented until taken
        zero_counts();
        cyc(1'b1, 8'h2B, 1'b1, 1'b1, 1'b0);
        repeat (4) cyc(1'b1, 8'h2B, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("irq.ack_pulses", ack_cnt, 1);

        // Masked interrupt request
        zero_counts();
        cyc(1'b1, 8'h38, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h2D, 1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("masked.ack_pulses", ack_cnt, 0);

        // Reset in the middle of RCALL
        cyc(1'b1, 8'h2C, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Ten back-to-back PUSH
        zero_counts();
        repeat (10) cyc(1'b1, 8'h2B, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("push10.we_pulses", we_cnt, 10);
        chk("push10.busy_cycles", busy_cnt, 0);
        chk("push10.ready_cycles", rdy_cnt, 11);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] id;
            id = ids[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) == 0) id = 8'($urandom);
            cyc(($urandom_range(0, 9) < 7), id, ($urandom_range(0, 9) == 0),
                1'($urandom), ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
